// File: rtl/fg_prog_pkg.sv
// Shared types and default sizing for the floating-gate programming sequencer.
package fg_prog_pkg;
  typedef enum logic [1:0] {
    OP_SEL = 2'd0,
    OP_INJ = 2'd1,
    OP_TUN = 2'd2,
    OP_RUN = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_GAP     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int DEF_ROW_BITS   = 4;
  localparam int DEF_COL_BITS   = 4;
  localparam int DEF_NUM_ROWS   = 3;
  localparam int DEF_NUM_COLS   = 6;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_SETTLE_CYC = 8;
endpackage

// File: rtl/fg_pulse_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module fg_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);
  logic [CNT_W-1:0] r_cnt;

  // Loading N-1 yields an interval of exactly N cycles, terminal cycle included.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_cnt <= '0;
    else if (i_load)          r_cnt <= i_load_val;
    else if (r_cnt != '0)     r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/fg_prog_sequencer.sv
// Sequences address setup, a counted pulse train and release for one FG
// programming command at a time, ending in a one-cycle done strobe.
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter int ROW_BITS   = DEF_ROW_BITS,
  parameter int COL_BITS   = DEF_COL_BITS,
  parameter int NUM_ROWS   = DEF_NUM_ROWS,
  parameter int NUM_COLS   = DEF_NUM_COLS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_op,
  input  logic [ROW_BITS-1:0] i_cmd_row,
  input  logic [COL_BITS-1:0] i_cmd_col,
  input  logic [7:0]          i_cmd_npulse,
  input  logic [CNT_W-1:0]    i_cmd_width,
  input  logic                i_abort,
  output logic [ROW_BITS-1:0] o_row_addr,
  output logic [COL_BITS-1:0] o_col_addr,
  output logic                o_dec_en,
  output logic [NUM_ROWS-1:0] o_drain_sel,
  output logic                o_vinj_pulse,
  output logic                o_tun_pulse,
  output logic                o_prog_en,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_aborted,
  output logic                o_err,
  output logic [7:0]          o_pulses_left
);
  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_SETUP   = ST_SETUP;
  localparam logic [2:0] S_PULSE   = ST_PULSE;
  localparam logic [2:0] S_GAP     = ST_GAP;
  localparam logic [2:0] S_RELEASE = ST_RELEASE;
  localparam logic [2:0] S_DONE    = ST_DONE;

  localparam logic [ROW_BITS:0] LP_NROWS     = (ROW_BITS+1)'(NUM_ROWS);
  localparam logic [COL_BITS:0] LP_NCOLS     = (COL_BITS+1)'(NUM_COLS);
  localparam logic [CNT_W-1:0]  LP_SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);

  logic [2:0]          r_state, w_nxt;
  logic [1:0]          r_op;
  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;
  logic [CNT_W-1:0]    r_wm1;
  logic [7:0]          r_left;
  logic                r_abt, r_prog, r_err;
  logic                w_accept, w_run, w_bad, w_go, w_active, w_addr_on;
  logic                w_tc, w_load, w_inj;
  logic [CNT_W-1:0]    w_load_val;

  assign w_accept = i_cmd_valid && (r_state == S_IDLE);
  assign w_run    = (i_cmd_op == OP_RUN);
  assign w_bad    = ({1'b0, i_cmd_row} >= LP_NROWS) || ({1'b0, i_cmd_col} >= LP_NCOLS);
  assign w_go     = w_accept && !w_run && !w_bad;
  assign w_active = (r_state == S_SETUP) || (r_state == S_PULSE) || (r_state == S_GAP);

  fg_pulse_timer #(.CNT_W(CNT_W)) u_tmr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // Every interval is timed by the single shared timer, reloaded on entry.
  always_comb begin
    w_nxt      = r_state;
    w_load     = 1'b0;
    w_load_val = LP_SETTLE_M1;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_run) w_nxt = S_DONE;
        else if (!w_bad) begin
          w_nxt  = S_SETUP;
          w_load = 1'b1;
        end
      end
      S_SETUP, S_PULSE, S_GAP: begin
        if (i_abort) begin
          w_nxt  = S_RELEASE;
          w_load = 1'b1;
        end else if (w_tc) begin
          w_load = 1'b1;
          if (r_state == S_PULSE) w_nxt = S_GAP;
          else if ((r_state == S_SETUP && r_op == OP_SEL) || r_left == 8'd0) w_nxt = S_RELEASE;
          else begin
            w_nxt      = S_PULSE;
            w_load_val = r_wm1;
          end
        end
      end
      S_RELEASE: if (w_tc) w_nxt = S_DONE;
      S_DONE:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_wm1   <= '0;
      r_left  <= '0;
      r_abt   <= 1'b0;
      r_prog  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_accept && !w_run && w_bad;
      if (w_go) begin
        r_op   <= i_cmd_op;
        r_row  <= i_cmd_row;
        r_col  <= i_cmd_col;
        r_wm1  <= (i_cmd_width == '0) ? '0 : i_cmd_width - CNT_W'(1);
        r_left <= i_cmd_npulse;
        r_prog <= 1'b1;
      end else if (r_state == S_PULSE && w_nxt == S_GAP) begin
        r_left <= r_left - 8'd1;
      end else if (r_state == S_DONE) begin
        r_left <= '0;
      end
      if (w_accept && w_run) r_prog <= 1'b0;
      // An abort that lands during release cannot shorten it but is still reported.
      if (w_accept) r_abt <= 1'b0;
      else if (i_abort && (w_active || r_state == S_RELEASE)) r_abt <= 1'b1;
    end
  end

  assign w_addr_on     = w_active || (r_state == S_RELEASE);
  assign w_inj         = (r_state == S_PULSE) && (r_op == OP_INJ);
  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_dec_en      = w_active;
  assign o_row_addr    = w_addr_on ? r_row : '0;
  assign o_col_addr    = w_addr_on ? r_col : '0;
  assign o_vinj_pulse  = w_inj;
  assign o_tun_pulse   = (r_state == S_PULSE) && (r_op == OP_TUN);
  assign o_drain_sel   = w_inj ? (NUM_ROWS'(1) << r_row) : '0;
  assign o_prog_en     = r_prog;
  assign o_done        = (r_state == S_DONE);
  assign o_aborted     = (r_state == S_DONE) && r_abt;
  assign o_err         = r_err;
  assign o_pulses_left = r_left;
endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Randomized bench for fg_prog_sequencer against a timing-formula model.
module tb_fg_prog_sequencer;
  localparam int S  = 8;
  localparam int NR = 3;
  localparam int NC = 6;

  typedef struct packed {
    logic       rdy, busy, dec;
    logic [3:0] row, col;
    logic [2:0] drn;
    logic       vinj, tun, prog, done, abt, err;
    logic [7:0] left;
  } obs_t;

  logic        i_clk = 1'b0, i_rst = 1'b1;
  logic        i_cmd_valid = 1'b0, i_abort = 1'b0;
  logic [1:0]  i_cmd_op = '0;
  logic [3:0]  i_cmd_row = '0, i_cmd_col = '0;
  logic [7:0]  i_cmd_npulse = '0;
  logic [15:0] i_cmd_width = '0;
  logic        o_cmd_ready, o_dec_en, o_vinj_pulse, o_tun_pulse, o_prog_en;
  logic        o_busy, o_done, o_aborted, o_err;
  logic [3:0]  o_row_addr, o_col_addr;
  logic [2:0]  o_drain_sel;
  logic [7:0]  o_pulses_left;

  fg_prog_sequencer #(.ROW_BITS(4), .COL_BITS(4), .NUM_ROWS(NR), .NUM_COLS(NC),
                      .CNT_W(16), .SETTLE_CYC(S)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_row(i_cmd_row), .i_cmd_col(i_cmd_col),
    .i_cmd_npulse(i_cmd_npulse), .i_cmd_width(i_cmd_width), .i_abort(i_abort),
    .o_row_addr(o_row_addr), .o_col_addr(o_col_addr), .o_dec_en(o_dec_en),
    .o_drain_sel(o_drain_sel), .o_vinj_pulse(o_vinj_pulse), .o_tun_pulse(o_tun_pulse),
    .o_prog_en(o_prog_en), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
    .o_err(o_err), .o_pulses_left(o_pulses_left)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  // Model of the command in flight: kind 0 = program, 1 = illegal, 2 = run-mode.
  bit m_has = 0;
  int m_T, m_kind, m_op, m_row, m_col, m_n, m_w, m_ab;
  bit m_prog_before = 0, m_prog_after = 0;

  int rec_done_r, rec_abt, rec_v_cnt, rec_v_first, rec_v_last, rec_t_cnt;
  int rec_d_cnt, rec_d_bad, rec_err_r, rec_busy_cnt, rec_prog1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic obs_t rst_obs();
    obs_t e;
    e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  // Pulses still owed after relative cycle x: one is consumed as each gap begins.
  function automatic int left_at(int x);
    int m;
    m = x - 1 - S;
    if (m < 0) return m_n;
    return m_n - m / (m_w + S) - (((m % (m_w + S)) >= m_w) ? 1 : 0);
  endfunction

  function automatic obs_t model_exp(int r);
    obs_t e;
    int neff, r0, rs, dn, m;
    e = '0;
    e.rdy  = 1'b1;
    e.prog = (r >= 1) ? m_prog_after : m_prog_before;
    if (r < 1) return e;
    if (m_kind == 1) begin e.err = (r == 1); return e; end
    if (m_kind == 2) begin
      if (r == 1) begin e.rdy = 0; e.busy = 1; e.done = 1; end
      return e;
    end
    neff = (m_op == 0) ? 0 : m_n;
    r0 = 1 + S + neff * (m_w + S);
    rs = (m_ab >= 1 && m_ab < r0) ? m_ab + 1 : r0;
    dn = rs + S;
    if (r > dn) return e;
    e.rdy = 0; e.busy = 1;
    if (r == dn) begin
      e.done = 1;
      e.abt  = (m_ab >= 1 && m_ab < dn);
      e.left = 8'(left_at(rs - 1));
      return e;
    end
    e.row  = 4'(m_row);
    e.col  = 4'(m_col);
    e.left = 8'(left_at((r < rs) ? r : rs - 1));
    if (r >= rs) return e;
    e.dec = 1;
    m = r - 1 - S;
    if (m >= 0 && (m % (m_w + S)) < m_w) begin
      e.vinj = (m_op == 1);
      e.tun  = (m_op == 2);
      if (m_op == 1) e.drn = 3'(1 << m_row);
    end
    return e;
  endfunction

  always @(negedge i_clk) begin : compare
    int r;
    obs_t o, e;
    r = m_has ? cyc - m_T : -1;
    o = {o_cmd_ready, o_busy, o_dec_en, o_row_addr, o_col_addr, o_drain_sel, o_vinj_pulse,
         o_tun_pulse, o_prog_en, o_done, o_aborted, o_err, o_pulses_left};
    e = i_rst ? rst_obs() : model_exp(r);
    chk("outputs", o, e);
    chk("pulse_excl", {31'd0, o.vinj & o.tun}, 32'd0);
    if (r == 0) begin
      rec_done_r = -1; rec_abt = -1; rec_v_cnt = 0; rec_v_first = -1; rec_v_last = -1;
      rec_t_cnt = 0; rec_d_cnt = 0; rec_d_bad = 0; rec_err_r = -1; rec_busy_cnt = 0;
      rec_prog1 = -1;
    end else if (r >= 1) begin
      if (o.done) begin rec_done_r = r; rec_abt = o.abt; end
      if (o.vinj) begin
        rec_v_cnt++;
        if (rec_v_first < 0) rec_v_first = r;
        rec_v_last = r;
        if (o.drn == 3'b100) rec_d_cnt++;
      end else if (o.drn != 3'b000) rec_d_bad++;
      if (o.tun)  rec_t_cnt++;
      if (o.err)  rec_err_r = r;
      if (o.busy) rec_busy_cnt++;
      if (r == 1) rec_prog1 = o.prog;
    end
  end

  // Issue one command in the current (idle) cycle and follow it to idle again,
  // or only up to relative cycle cut when cut >= 0.
  task automatic do_cmd(input int op, input int row, input int col, input int n,
                        input int width, input int ab, input int cut);
    int last, neff, r0;
    m_prog_before = m_prog_after;
    m_op = op; m_row = row; m_col = col; m_n = n; m_ab = ab;
    m_w = (width == 0) ? 1 : width;
    if (op == 3) begin
      m_kind = 2; m_prog_after = 0; last = 1;
    end else if (row >= NR || col >= NC) begin
      m_kind = 1; last = 1;
    end else begin
      m_kind = 0; m_prog_after = 1;
      neff = (op == 0) ? 0 : n;
      r0 = 1 + S + neff * (m_w + S);
      last = ((ab >= 1 && ab < r0) ? ab + 1 : r0) + S;
    end
    m_T = cyc; m_has = 1;
    i_cmd_valid = 1; i_cmd_op = 2'(op); i_cmd_row = 4'(row); i_cmd_col = 4'(col);
    i_cmd_npulse = 8'(n); i_cmd_width = 16'(width); i_abort = 0;
    for (int r = 1; r <= last + 1; r++) begin
      if (cut >= 0 && r > cut) break;
      @(posedge i_clk); #1;
      i_abort      = (r == ab);
      i_cmd_valid  = (m_kind == 0 && r <= last) ? ($urandom_range(0, 3) == 0) : 1'b0;
      i_cmd_op     = 2'($urandom);
      i_cmd_row    = 4'($urandom);
      i_cmd_col    = 4'($urandom);
      i_cmd_npulse = 8'($urandom);
      i_cmd_width  = 16'($urandom);
    end
  endtask

  initial begin
    int op, row, col, n, w, ab, neff, r0;
    repeat (3) @(posedge i_clk);
    #3 i_rst = 0;
    @(posedge i_clk); #1;
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_prog", o_prog_en, 0);

    do_cmd(1, 2, 5, 2, 4, -1, -1);
    chk("inj_done_t", rec_done_r, 41);
    chk("inj_aborted", rec_abt, 0);
    chk("inj_first", rec_v_first, 9);
    chk("inj_last", rec_v_last, 24);
    chk("inj_cycles", rec_v_cnt, 8);
    chk("inj_drain", rec_d_cnt, 8);
    chk("inj_drain_off", rec_d_bad, 0);
    chk("inj_prog", o_prog_en, 1);

    do_cmd(2, 1, 1, 0, 3, -1, -1);
    chk("tun0_done_t", rec_done_r, 17);
    chk("tun0_pulses", rec_t_cnt, 0);

    do_cmd(1, 3, 0, 1, 1, -1, -1);
    chk("ill_err_t", rec_err_r, 1);
    chk("ill_busy", rec_busy_cnt, 0);
    chk("ill_pulses", rec_v_cnt, 0);

    do_cmd(1, 0, 2, 3, 4, 10, -1);
    chk("abt_done_t", rec_done_r, 19);
    chk("abt_cycles", rec_v_cnt, 2);
    chk("abt_aborted", rec_abt, 1);

    do_cmd(3, 0, 0, 0, 0, -1, -1);
    chk("run_done_t", rec_done_r, 1);
    chk("run_prog", rec_prog1, 0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        i_abort = 1'($urandom);
        @(posedge i_clk); #1;
      end
      i_abort = 0;
      op  = $urandom_range(0, 3);
      row = $urandom_range(0, 3);
      col = $urandom_range(0, 6);
      n   = $urandom_range(0, 3);
      w   = $urandom_range(0, 4);
      neff = (op == 0) ? 0 : n;
      r0 = 1 + S + neff * (((w == 0) ? 1 : w) + S);
      ab = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, r0 + S);
      do_cmd(op, row, col, n, w, ab, -1);
    end

    do_cmd(1, 1, 3, 2, 5, -1, 11);
    chk("pre_rst_vinj", o_vinj_pulse, 1);
    #2;
    i_rst = 1; i_cmd_valid = 0; i_abort = 0;
    m_has = 0; m_prog_before = 0; m_prog_after = 0;
    #1;
    chk("arst_vinj", o_vinj_pulse, 0);
    chk("arst_prog", o_prog_en, 0);
    chk("arst_dec", o_dec_en, 0);
    chk("arst_ready", o_cmd_ready, 1);
    @(posedge i_clk);
    #3 i_rst = 0;
    @(posedge i_clk); #1;

    do_cmd(0, 2, 4, 5, 2, -1, -1);
    chk("sel_done_t", rec_done_r, 17);
    chk("sel_pulses", rec_v_cnt + rec_t_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
